uart_tx_rx_scheduler: RTL

Shares one UART_Top instance between NUM_REQ transmit requesters using round-robin arbitration. Also services the UART receive side: it captures each received byte, clears the UART ready flag, and offers the byte on a valid/ready port. It sits between the UART_Top core (data_in, wr_en, busy, rdy, rdy_clr, data_out) and the SoC-side clients.

---
 rtl/uart_tx_rx_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_rx_scheduler.sv
// Round-robin transmit arbiter in front of a single UART_Top core.
// It also captures received bytes and offers them on a valid/ready port.
module uart_tx_rx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         uart_data_in,
    output logic                      uart_wr_en,
    input  logic                      uart_busy,
    input  logic                      uart_rdy,
    output logic                      uart_rdy_clr,
    input  logic [DATA_W-1:0]         uart_data_out,
    output logic                      rx_valid,
    output logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_ready,
    output logic [IDW-1:0]            grant_id,
    output logic                      tx_active,
    output logic                      tx_timeout
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] T_IDLE      = 2'd0;
    localparam logic [1:0] T_ISSUE     = 2'd1;
    localparam logic [1:0] T_WAIT_BUSY = 2'd2;
    localparam logic [1:0] T_WAIT_DONE = 2'd3;

    localparam logic [1:0] R_IDLE     = 2'd0;
    localparam logic [1:0] R_CLR      = 2'd1;
    localparam logic [1:0] R_WAIT_LOW = 2'd2;

    logic [1:0]     tstate;
    logic [1:0]     rstate;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] nxt;
    logic           found;
    logic [CW-1:0]  cnt;
    int             idx;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    assign nxt = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tstate       <= T_IDLE;
            ptr          <= '0;
            cnt          <= '0;
            req_ready    <= '0;
            uart_data_in <= '0;
            uart_wr_en   <= 1'b0;
            grant_id     <= '0;
            tx_active    <= 1'b0;
            tx_timeout   <= 1'b0;
        end else begin
            req_ready  <= '0;
            uart_wr_en <= 1'b0;
            case (tstate)
                T_IDLE: begin
                    if (found && !uart_busy) begin
                        uart_data_in <= req_data[int'(pick)*DATA_W +: DATA_W];
                        grant_id     <= pick;
                        req_ready    <= NUM_REQ'(1) << pick;
                        tx_active    <= 1'b1;
                        ptr          <= nxt;
                        tstate       <= T_ISSUE;
                    end
                end
                T_ISSUE: begin
                    uart_wr_en <= 1'b1;
                    cnt        <= '0;
                    tstate     <= T_WAIT_BUSY;
                end
                T_WAIT_BUSY: begin
                    if (uart_busy) begin
                        tstate <= T_WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        // The core never started: drop the byte and move on.
                        tx_timeout <= 1'b1;
                        tx_active  <= 1'b0;
                        tstate     <= T_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                T_WAIT_DONE: begin
                    if (!uart_busy) begin
                        tx_active <= 1'b0;
                        tstate    <= T_IDLE;
                    end
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rstate       <= R_IDLE;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            uart_rdy_clr <= 1'b0;
        end else begin
            uart_rdy_clr <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (rstate)
                R_IDLE: begin
                    // A capture overrides a same-cycle consume.
                    if (uart_rdy && (!rx_valid || rx_ready)) begin
                        rx_data      <= uart_data_out;
                        rx_valid     <= 1'b1;
                        uart_rdy_clr <= 1'b1;
                        rstate       <= R_CLR;
                    end
                end
                R_CLR: rstate <= R_WAIT_LOW;
                R_WAIT_LOW: begin
                    if (!uart_rdy) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule
